// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      md_op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] md_result;

    modport master (
        output start, md_op, src_a, src_b, flush,
        input  busy, done, md_result
    );

    modport slave (
        input  start, md_op, src_a, src_b, flush,
        output busy, done, md_result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: magnitudes are iterated for 32 cycles,
// then sign-corrected and selected in a single fix-up cycle.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave md
);

    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   acc_hi, acc_lo, opnd;
    logic              neg_q, neg_r;
    logic [CNT_W-1:0]  cnt;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic              is_div, div_zero, div_ovf, special, accept;
    logic [XLEN-1:0]   a_mag, b_mag, special_res;
    logic [XLEN:0]     mul_sum, div_shift, div_trial;
    logic              div_ok;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_res;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        logic signed [XLEN-1:0] s;
        s = $signed(v);
        return neg ? $unsigned(-s) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] v, input logic neg);
        logic signed [2*XLEN-1:0] s;
        s = $signed(v);
        return neg ? $unsigned(-s) : v;
    endfunction

    // Request decode: operand magnitudes, result signs and the early-exit cases
    always_comb begin
        a_signed    = md.md_op inside {3'd1, 3'd2, 3'd4, 3'd6};
        b_signed    = md.md_op inside {3'd1, 3'd4, 3'd6};
        a_neg       = a_signed && ($signed(md.src_a) < 0);
        b_neg       = b_signed && ($signed(md.src_b) < 0);
        a_mag       = neg_if(md.src_a, a_neg);
        b_mag       = neg_if(md.src_b, b_neg);
        is_div      = md.md_op[2];
        div_zero    = is_div && (md.src_b == '0);
        div_ovf     = is_div && !md.md_op[0] && (md.src_a == MIN_NEG) && (md.src_b == '1);
        special     = div_zero || div_ovf;
        special_res = div_zero ? (md.md_op[1] ? md.src_a : '1)
                               : (md.md_op[1] ? '0 : MIN_NEG);
        accept      = (state_q == IDLE) && md.start && !md.flush;
    end

    // One iteration step; acc_hi/acc_lo hold product halves or remainder/quotient
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_trial = div_shift - {1'b0, opnd};
        div_ok    = !div_trial[XLEN];
    end

    // Fix-up: sign correction and result select
    always_comb begin
        prod_fix = neg_if_wide({acc_hi, acc_lo}, neg_q);
        fix_res  = prod_fix[XLEN-1:0];
        case (op_q)
            3'd1, 3'd2, 3'd3: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fix_res = neg_if(acc_lo, neg_q);
            3'd6, 3'd7:       fix_res = neg_if(acc_hi, neg_r);
            default:          fix_res = prod_fix[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (md.flush) state_d = IDLE;
                     else if (cnt == LAST) state_d = FIX;
            FIX:     state_d = md.flush ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign md.busy = (state_q != IDLE);
    assign md.done = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= '0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            opnd         <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            cnt          <= '0;
            md.md_result <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q   <= md.md_op;
                    acc_hi <= '0;
                    acc_lo <= is_div ? a_mag : b_mag;
                    opnd   <= is_div ? b_mag : a_mag;
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    cnt    <= '0;
                    if (special) md.md_result <= special_res;
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (op_q[2]) begin
                        acc_hi <= div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], div_ok};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
                    end
                end
                FIX: if (!md.flush) md.md_result <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the TINUC execute stage, beside the combinational ALU.
- Takes the same src_a/src_b operands the ALU receives and returns a 32-bit result to the same writeback mux.
- Multi-cycle. The pipeline stalls on busy and captures result on the done pulse.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must be able to hold XLEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- md_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src_a  input  32  rs1 operand (multiplicand/dividend); captured on start acceptance.
- src_b  input  32  rs2 operand (multiplier/divisor); captured on start acceptance.
- flush  input  1  pipeline kill; aborts any operation in flight.
- busy  output  1  high from the cycle after acceptance until DONE is left.
- done  output  1  single-cycle pulse; result valid in this cycle.
- md_result  output  32  result; held stable from done until the next acceptance.

Behaviour:
- Reset: rst_n low forces the following immediately, regardless of clk.
  - State goes to IDLE.
  - busy=0, done=0, md_result=0.
  - Counter and internal registers are cleared.
  - This applies equally in the middle of an operation; no result is produced afterwards.
- States:
  - IDLE: waiting for start.
  - CALC: iterating.
  - FIX: sign correction and result select.
  - DONE: done=1 for one cycle.
- IDLE with start=1 and flush=0 (call the acceptance edge cycle 0):
  - Latch md_op.
  - Latch |src_a| and |src_b| for signed operands, recording the result sign.
  - Signedness: MULH, DIV, REM treat both operands as signed. MULHSU treats src_a as signed and src_b as unsigned. MULHU, DIVU, REMU treat both as unsigned.
  - Clear the counter.
  - Go to CALC, or go straight to DONE for a special case.
- Special cases go IDLE→DONE, so done is high in cycle 1:
  - Divide by zero (src_b=0): DIV/DIVU give 32'hFFFFFFFF; REM/REMU give src_a.
  - Signed overflow (src_a=32'h80000000, src_b=32'hFFFFFFFF): DIV gives 32'h80000000; REM gives 0.
- CALC, multiply: radix-2 shift-add on a 64-bit product, one multiplier bit per cycle.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle, keeping a 32-bit remainder.
- CALC lasts exactly 32 cycles (cycles 1..32), counter 0..31. When the counter reaches 31, go to FIX.
- FIX (cycle 33):
  - Negate the product when the sign flag is set.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - Select the result: MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32 bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Register md_result and go to DONE.
- DONE (cycle 34): done=1, busy=1. Next state is IDLE.
- Normal latency: done in cycle 34 after acceptance. Special-case latency: done in cycle 1.
- busy:
  - 1 in CALC, FIX and DONE; 0 in IDLE.
  - For special cases, busy is 1 only in the DONE cycle.
- Back-to-back requests: start is ignored while not in IDLE. A start in the DONE cycle is dropped; it is accepted in the following IDLE cycle.
- flush:
  - In IDLE, flush=1 blocks acceptance even when start=1.
  - In CALC or FIX, flush=1 returns the unit to IDLE at the next edge. No done pulse, and md_result keeps its previous value.
  - In DONE, flush has no effect and done still pulses.
- md_result changes only on the FIX→DONE or special-case→DONE transition. Arithmetic is modulo 2^32 except where the high product word is selected.

Test Plan:
- MUL 7×(-3): src_a=7, src_b=32'hFFFFFFFD, start. Required: done in cycle 34, md_result=32'hFFFFFFEB, busy high in cycles 1–34, done high only in cycle 34.
- High products: MULHU 32'hFFFFFFFF×32'hFFFFFFFF gives 32'hFFFFFFFE. MULH with the same operands gives 0. MULHSU -1×2 gives 32'hFFFFFFFF.
- Signed divide and remainder: DIV -20/6 gives 32'hFFFFFFFD. REM -20/6 gives 32'hFFFFFFFE. DIVU 100/7 gives 14. REMU 100/7 gives 2.
- Special cases:
  - DIV 5/0 gives 32'hFFFFFFFF; REMU 5/0 gives 5. Both have done in cycle 1.
  - DIV 32'h80000000/-1 gives 32'h80000000 with done in cycle 1.
- Control:
  - flush in cycle 10 of a DIV: no done, md_result unchanged, busy=0 in cycle 11.
  - start held high through DONE: the second operation is accepted exactly one cycle after DONE.
- Reset: rst_n driven low mid-CALC (asynchronously, between edges). Required: busy, done and md_result go to 0 immediately; after release the unit accepts a new MUL 3×4 and returns 12.
